inst_mem_loader: RTL and testbench

Host-side writer for the PicoRV32 instruction-memory write port. It accepts a framed byte stream (count header, little-endian program words, optional checksum) over a valid/ready handshake. It drives `inst_mem_en`/`inst_mem_wen`/`inst_mem_addr`/`inst_mem_data` of `picorv32_top` and holds the core in reset until a complete program image has been written.

---
 rtl/inst_mem_loader.sv | 202 ++++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: writes a framed little-endian byte stream into the PicoRV32
// instruction memory. Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module inst_mem_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_load_req,
  output logic              o_inst_mem_en,
  output logic [3:0]        o_inst_mem_wen,
  output logic [ADDR_W-1:0] o_inst_mem_addr,
  output logic [31:0]       o_inst_mem_data,
  output logic              o_core_resetn,
  output logic              o_load_done,
  output logic              o_load_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CNT = 3'd1, S_DATA = 3'd2, S_DONE = 3'd3, S_ERR = 3'd4, S_CHK = 3'd5
  } state_t;
  localparam state_t S_AFTER = S_CHK;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CNT = 3'd1, S_DATA = 3'd2, S_DONE = 3'd3, S_ERR = 3'd4
  } state_t;
  localparam state_t S_AFTER = S_DONE;
`endif

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t              r_state;
  state_t              w_state_dec;
  state_t              w_state_nxt;
  logic                r_in_ready;
  logic                r_core_resetn;
  logic                r_load_done;
  logic                r_load_err;
  logic                w_ready_nxt;
  logic                w_done_nxt;
  logic                w_err_nxt;
  logic                r_mem_en;
  logic [3:0]          r_mem_wen;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_data;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_cnt_lo;
  logic [15:0]         r_count;
  logic [16:0]         r_word_cnt;
  logic [1:0]          r_idx;
  logic [23:0]         r_shift;
  logic                w_accept;
  logic [15:0]         w_count;
  logic                w_oversize;
  logic                w_last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          r_xor;
  logic                w_sum_ok;
  assign w_sum_ok = (i_in_data == r_xor);
`endif

  // A byte presented alongside load_req is never consumed.
  assign w_accept    = i_in_valid && r_in_ready && !i_load_req;
  assign w_count     = {i_in_data, r_cnt_lo};
  assign w_oversize  = ({1'b0, w_count} > DEPTH);
  assign w_last_word = ((r_word_cnt + 17'd1) == {1'b0, r_count});

  // Next-state decode and the values the status registers load next.
  always_comb begin
    w_state_dec = r_state;
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_dec = S_CNT;
        else          w_state_dec = r_state;
      end
      S_CNT: begin
        if (!w_accept)              w_state_dec = r_state;
        else if (w_oversize)        w_state_dec = S_ERR;
        else if (w_count == 16'd0)  w_state_dec = S_AFTER;
        else                        w_state_dec = S_DATA;
      end
      S_DATA: begin
        if (w_accept && (r_idx == 2'd3) && w_last_word) w_state_dec = S_AFTER;
        else                                            w_state_dec = r_state;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (!w_accept)     w_state_dec = r_state;
        else if (w_sum_ok) w_state_dec = S_DONE;
        else               w_state_dec = S_ERR;
      end
`endif
      S_DONE:  w_state_dec = S_DONE;
      S_ERR:   w_state_dec = S_ERR;
      default: w_state_dec = S_IDLE;
    endcase
    if (i_load_req) begin
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = w_state_dec;
    end
    w_ready_nxt = !i_load_req && (w_state_nxt != S_DONE) && (w_state_nxt != S_ERR);
    // Release waits one cycle after entering DONE so the last write strobe has retired.
`ifdef LOADER_CHECKSUM_EN
    w_done_nxt = (w_state_nxt == S_DONE) && ((r_state == S_DONE) || (r_state == S_CHK));
`else
    w_done_nxt = (w_state_nxt == S_DONE) && (r_state == S_DONE);
`endif
    w_err_nxt = (w_state_nxt == S_ERR);
  end

  // State and status registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_in_ready    <= 1'b1;
      r_core_resetn <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_in_ready    <= w_ready_nxt;
      r_core_resetn <= w_done_nxt;
      r_load_done   <= w_done_nxt;
      r_load_err    <= w_err_nxt;
    end
  end

  // Byte assembly, write strobe and frame bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_en   <= 1'b0;
      r_mem_wen  <= 4'b0000;
      r_mem_addr <= {ADDR_W{1'b0}};
      r_mem_data <= 32'h0000_0000;
      r_addr     <= {ADDR_W{1'b0}};
      r_cnt_lo   <= 8'h00;
      r_count    <= 16'h0000;
      r_word_cnt <= 17'd0;
      r_idx      <= 2'd0;
      r_shift    <= 24'h00_0000;
`ifdef LOADER_CHECKSUM_EN
      r_xor      <= 8'h00;
`endif
    end else if (i_load_req) begin
      r_mem_en   <= 1'b0;
      r_mem_wen  <= 4'b0000;
      r_addr     <= {ADDR_W{1'b0}};
      r_word_cnt <= 17'd0;
      r_idx      <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
      r_xor      <= 8'h00;
`endif
    end else begin
      r_mem_en  <= 1'b0;
      r_mem_wen <= 4'b0000;
      if (w_accept) begin
        case (r_state)
          S_IDLE: r_cnt_lo <= i_in_data;
          S_CNT:  r_count  <= w_count;
          S_DATA: begin
            if (r_idx == 2'd3) begin
              r_mem_en   <= 1'b1;
              r_mem_wen  <= 4'b1111;
              r_mem_addr <= r_addr;
              r_mem_data <= {i_in_data, r_shift};
              r_addr     <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
              r_word_cnt <= r_word_cnt + 17'd1;
            end else begin
              r_shift <= {i_in_data, r_shift[23:8]};
            end
            r_idx <= r_idx + 2'd1;
          end
          default: begin
          end
        endcase
`ifdef LOADER_CHECKSUM_EN
        if ((r_state == S_IDLE) || (r_state == S_CNT) || (r_state == S_DATA)) begin
          r_xor <= r_xor ^ i_in_data;
        end
`endif
      end
    end
  end

  assign o_in_ready      = r_in_ready;
  assign o_inst_mem_en   = r_mem_en;
  assign o_inst_mem_wen  = r_mem_wen;
  assign o_inst_mem_addr = r_mem_addr;
  assign o_inst_mem_data = r_mem_data;
  assign o_core_resetn   = r_core_resetn;
  assign o_load_done     = r_load_done;
  assign o_load_err      = r_load_err;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader with ADDR_W = 12; follows the
// LOADER_CHECKSUM_EN setting of the build.
`timescale 1ns/1ps
module tb_inst_mem_loader;
  localparam int ADDR_W = 12;
  localparam int LOGN   = 8192;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              load_req;
  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              core_resetn;
  logic              load_done;
  logic              load_err;

  int checks = 0;
  int errors = 0;
  int wr_n = 0;
  int wen_bad = 0;
  logic [ADDR_W-1:0] wr_addr [0:LOGN-1];
  logic [31:0]       wr_data [0:LOGN-1];
  logic [7:0]        fb [$];
  logic [31:0]       ref_data [0:63];

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_in_data(in_data), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_load_req(load_req), .o_inst_mem_en(mem_en),
    .o_inst_mem_wen(mem_wen), .o_inst_mem_addr(mem_addr), .o_inst_mem_data(mem_data),
    .o_core_resetn(core_resetn), .o_load_done(load_done), .o_load_err(load_err)
  );

  // Write log, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (mem_en === 1'b1) begin
      if (mem_wen !== 4'b1111) wen_bad++;
      if (wr_n < LOGN) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_data;
      end
      wr_n++;
    end else if (mem_wen !== 4'b0000) begin
      wen_bad++;
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] seed, input int i);
    return seed + (32'(i) * 32'h0103_0507);
  endfunction

  task automatic build_frame(input int n, input logic [31:0] seed);
    logic [15:0] n16;
    logic [31:0] w;
    logic [7:0]  x;
    n16 = 16'(n);
    fb.delete();
    fb.push_back(n16[7:0]);
    fb.push_back(n16[15:8]);
    for (int i = 0; i < n; i++) begin
      w = exp_word(seed, i);
      for (int b = 0; b < 4; b++) fb.push_back(w[8*b +: 8]);
    end
    x = 8'h00;
    foreach (fb[k]) x = x ^ fb[k];
`ifdef LOADER_CHECKSUM_EN
    fb.push_back(x);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i]);
      if (gap_max > 0 && i < fb.size() - 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (load_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Pulses load_req with a byte on the bus that must not be consumed.
  task automatic do_load_req();
    load_req = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    load_req = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || core_resetn !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_req_block: ready/resetn/done/err=%b%b%b%b required 0000",
               in_ready, core_resetn, load_done, load_err);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_req_reopen: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; load_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, mem_en, mem_wen, mem_addr, mem_data, core_resetn, load_done, load_err} !==
        {1'b1, 1'b0, 4'b0000, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: ready=%b en=%b wen=%h addr=%h data=%h resetn=%b done=%b err=%b required 1 0 0 000 00000000 0 0 0",
               in_ready, mem_en, mem_wen, mem_addr, mem_data, core_resetn, load_done, load_err);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || core_resetn !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b resetn=%b required 1 0", in_ready, core_resetn);
    end
  endtask

  task automatic test_basic(input logic [7:0] sum);
    int base;
    base = wr_n;
    fb = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    fb.push_back(sum);
`endif
    send_frame(0);
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (sum == 8'h7E) begin
      if (core_resetn !== 1'b1 || load_done !== 1'b1 || load_err !== 1'b0) begin
        errors++;
        $display("FAIL chk_good_release: resetn=%b done=%b err=%b required 1 1 0", core_resetn, load_done, load_err);
      end
    end else begin
      if (core_resetn !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b1) begin
        errors++;
        $display("FAIL chk_bad_reject: resetn=%b done=%b err=%b required 0 0 1", core_resetn, load_done, load_err);
      end
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL chk_ready_low: in_ready=%b required 0", in_ready);
    end
`else
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 12'h001 || mem_data !== 32'h0000_006F || core_resetn !== 1'b0) begin
      errors++;
      $display("FAIL basic_strobe: en=%b addr=%h data=%h resetn=%b required 1 001 0000006f 0",
               mem_en, mem_addr, mem_data, core_resetn);
    end
    @(negedge clk);
    checks++;
    if (core_resetn !== 1'b1 || load_done !== 1'b1 || mem_en !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: resetn=%b done=%b en=%b ready=%b required 1 1 0 0",
               core_resetn, load_done, mem_en, in_ready);
    end
`endif
    checks++;
    if (wr_n - base != 2 || wr_addr[base] !== 12'h000 || wr_data[base] !== 32'h0000_0013 ||
        wr_addr[base+1] !== 12'h001 || wr_data[base+1] !== 32'h0000_006F || wen_bad != 0) begin
      errors++;
      $display("FAIL basic_writes: n=%0d a0=%h d0=%h a1=%h d1=%h wen_bad=%0d required 2 000 00000013 001 0000006f 0",
               wr_n - base, wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1], wen_bad);
    end
  endtask

  task automatic test_oversize();
    int base;
    do_load_req();
    base = wr_n;
    send_byte(8'h01);
    send_byte(8'h10);
    in_valid = 1'b0;
    checks++;
    if (load_err !== 1'b1 || core_resetn !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL oversize_err: err=%b resetn=%b done=%b required 1 0 0", load_err, core_resetn, load_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n != base || in_ready !== 1'b0 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL oversize_hold: writes=%0d ready=%b err=%b required 0 0 1", wr_n - base, in_ready, load_err);
    end
  endtask

  task automatic test_count_zero();
    int base;
    do_load_req();
    base = wr_n;
    build_frame(0, 32'h0);
    send_frame(0);
`ifndef LOADER_CHECKSUM_EN
    checks++;
    if (core_resetn !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_early: resetn=%b done=%b required 0 0", core_resetn, load_done);
    end
    @(negedge clk);
`endif
    checks++;
    if (core_resetn !== 1'b1 || load_done !== 1'b1 || wr_n != base) begin
      errors++;
      $display("FAIL zero_done: resetn=%b done=%b writes=%0d required 1 1 0", core_resetn, load_done, wr_n - base);
    end
  endtask

  task automatic test_load_req_abort();
    int base;
    int base2;
    do_load_req();
    base = wr_n;
    build_frame(2, 32'h1122_3344);
    for (int i = 0; i < 7; i++) send_byte(fb[i]);
    do_load_req();
    checks++;
    if (wr_n - base != 1) begin
      errors++;
      $display("FAIL abort_partial_writes: n=%0d required 1", wr_n - base);
    end
    base2 = wr_n;
    build_frame(1, 32'hDEAD_BEEF);
    send_frame(0);
`ifndef LOADER_CHECKSUM_EN
    checks++;
    if (core_resetn !== 1'b0) begin
      errors++;
      $display("FAIL abort_resetn_early: resetn=%b required 0", core_resetn);
    end
    @(negedge clk);
`endif
    checks++;
    if (core_resetn !== 1'b1 || wr_n - base2 != 1 || wr_addr[base2] !== 12'h000 || wr_data[base2] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL abort_reload: resetn=%b n=%0d addr=%h data=%h required 1 1 000 deadbeef",
               core_resetn, wr_n - base2, wr_addr[base2], wr_data[base2]);
    end
  endtask

  task automatic test_gaps();
    int base;
    bit ok;
    do_load_req();
    base = wr_n;
    build_frame(64, 32'hC0FF_EE00);
    send_frame(0);
    wait_done(ok);
    for (int i = 0; i < 64; i++) ref_data[i] = wr_data[base+i];
    do_load_req();
    base = wr_n;
    send_frame(3);
    wait_done(ok);
    checks++;
    if (!ok || wr_n - base != 64) begin
      errors++;
      $display("FAIL gaps_done: done=%b writes=%0d required 1 64", ok, wr_n - base);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (wr_addr[base+i] !== 12'(i) || wr_data[base+i] !== ref_data[i] ||
          wr_data[base+i] !== exp_word(32'hC0FF_EE00, i)) begin
        errors++;
        $display("FAIL gaps_word%0d: addr=%h data=%h required %h %h", i,
                 wr_addr[base+i], wr_data[base+i], 12'(i), exp_word(32'hC0FF_EE00, i));
      end
    end
  endtask

  task automatic test_max_count();
    int base;
    int bad;
    bit ok;
    do_load_req();
    base = wr_n;
    build_frame(4096, 32'h0BAD_F00D);
    send_frame(0);
    wait_done(ok);
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if (wr_addr[base+i] !== 12'(i) || wr_data[base+i] !== exp_word(32'h0BAD_F00D, i)) bad++;
    end
    checks++;
    if (!ok || load_err !== 1'b0 || wr_n - base != 4096 || bad != 0 || wen_bad != 0) begin
      errors++;
      $display("FAIL max_count: done=%b err=%b writes=%0d bad=%0d wen_bad=%0d required 1 0 4096 0 0",
               ok, load_err, wr_n - base, bad, wen_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic(8'h7E);
`ifdef LOADER_CHECKSUM_EN
    do_load_req();
    test_basic(8'h7F);
`endif
    test_oversize();
    test_count_zero();
    test_load_req_abort();
    test_gaps();
    test_max_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
